pacman_move_ctrl: RTL and testbench

- Sequences the Pac-Man sprite's position and direction, which feed the sprite renderer's pm_xpos/pm_ypos/pm_direction inputs.
- Buffers the player's requested turn and steps the sprite once every STEP_DIV frame ticks.
- Before each step it asks the external maze wall-lookup unit, over a req/ack handshake, whether the candidate position is legal.
- Adopts the buffered turn when legal; otherwise continues straight or stops.

---
 rtl/pacman_move_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_pacman_move_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_move_ctrl.sv
// Pac-Man movement sequencer: buffers turn requests, divides frame ticks into
// steps, and checks each candidate position with the maze wall-lookup unit first.
module pacman_move_ctrl #(
  parameter logic [9:0] START_X  = 10'd305,
  parameter logic [9:0] START_Y  = 10'd350,
  parameter int         STEP     = 2,
  parameter int         STEP_DIV = 2,
  parameter logic [9:0] X_MIN    = 10'd144,
  parameter logic [9:0] X_MAX    = 10'd754,
  parameter logic [9:0] Y_MIN    = 10'd35,
  parameter logic [9:0] Y_MAX    = 10'd485
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [3:0] btn,
  output logic       wall_req,
  output logic [9:0] wall_x,
  output logic [9:0] wall_y,
  input  logic       wall_ack,
  input  logic       wall_hit,
  output logic [9:0] pm_xpos,
  output logic [9:0] pm_ypos,
  output logic [3:0] pm_direction,
  output logic       moving,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_Q_PEND = 3'd1,
    S_W_PEND = 3'd2,
    S_Q_CUR  = 3'd3,
    S_W_CUR  = 3'd4,
    S_COMMIT = 3'd5
  } state_t;

  localparam logic [3:0]         DIV_LAST = 4'(STEP_DIV - 1);
  localparam logic signed [10:0] STEP_S   = 11'(STEP);
  localparam logic signed [10:0] XMIN_S   = $signed({1'b0, X_MIN});
  localparam logic signed [10:0] XMAX_S   = $signed({1'b0, X_MAX});
  localparam logic signed [10:0] YMIN_S   = $signed({1'b0, Y_MIN});
  localparam logic signed [10:0] YMAX_S   = $signed({1'b0, Y_MAX});

  // Returns {in_bounds, x, y}; a non-one-hot heading is never legal.
  function automatic logic [20:0] cand_f(input logic [3:0] dir, input logic [9:0] x,
                                         input logic [9:0] y);
    logic signed [10:0] cx;
    logic signed [10:0] cy;
    logic               dir_ok;
    logic               ok;
    cx     = $signed({1'b0, x});
    cy     = $signed({1'b0, y});
    dir_ok = 1'b1;
    case (dir)
      4'b0001: cx = cx + STEP_S;
      4'b0010: cx = cx - STEP_S;
      4'b0100: cy = cy - STEP_S;
      4'b1000: cy = cy + STEP_S;
      default: dir_ok = 1'b0;
    endcase
    ok = dir_ok && (cx >= XMIN_S) && (cx <= XMAX_S) && (cy >= YMIN_S) && (cy <= YMAX_S);
    return {ok, cx[9:0], cy[9:0]};
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  div_r;
  logic [3:0]  pend_r;
  logic [3:0]  qdir_r;
  logic [3:0]  btn_sel_s;
  logic [9:0]  xpos_r;
  logic [9:0]  ypos_r;
  logic [3:0]  dir_r;
  logic        moving_r;
  logic        busy_r;
  logic        wall_req_r;
  logic [9:0]  wall_x_r;
  logic [9:0]  wall_y_r;
  logic        trigger_s;
  logic [20:0] cand_pend_s;
  logic [20:0] cand_cur_s;

  assign trigger_s   = enable && frame_tick && (div_r == DIV_LAST);
  assign cand_pend_s = cand_f(pend_r, xpos_r, ypos_r);
  assign cand_cur_s  = cand_f(dir_r, xpos_r, ypos_r);

  // Button priority encoder: right > left > up > down.
  always_comb begin
    btn_sel_s = 4'b0000;
    if (btn[0]) begin
      btn_sel_s = 4'b0001;
    end else if (btn[1]) begin
      btn_sel_s = 4'b0010;
    end else if (btn[2]) begin
      btn_sel_s = 4'b0100;
    end else if (btn[3]) begin
      btn_sel_s = 4'b1000;
    end else begin
      btn_sel_s = 4'b0000;
    end
  end

  // Frame-tick divider; keeps counting even while a step is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r <= 4'd0;
    end else if (enable && frame_tick) begin
      div_r <= (div_r == DIV_LAST) ? 4'd0 : div_r + 4'd1;
    end
  end

  // Turn buffer: a fresh press always overrides; cleared once adopted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= 4'b0000;
    end else if (btn != 4'b0000) begin
      pend_r <= btn_sel_s;
    end else if ((state_r == S_COMMIT) && (qdir_r == pend_r)) begin
      pend_r <= 4'b0000;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != S_IDLE);
    end
  end

  // Next-state logic: try the buffered turn first, then straight ahead.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (trigger_s) begin
          if ((pend_r != 4'b0000) && (pend_r != dir_r)) state_nxt_s = S_Q_PEND;
          else state_nxt_s = S_Q_CUR;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_Q_PEND: begin
        if (cand_pend_s[20]) state_nxt_s = S_W_PEND;
        else state_nxt_s = S_Q_CUR;
      end
      S_W_PEND: begin
        if (wall_ack) begin
          if (wall_hit) state_nxt_s = S_Q_CUR;
          else state_nxt_s = S_COMMIT;
        end else begin
          state_nxt_s = S_W_PEND;
        end
      end
      S_Q_CUR: begin
        if (cand_cur_s[20]) state_nxt_s = S_W_CUR;
        else state_nxt_s = S_IDLE;
      end
      S_W_CUR: begin
        if (wall_ack) begin
          if (wall_hit) state_nxt_s = S_IDLE;
          else state_nxt_s = S_COMMIT;
        end else begin
          state_nxt_s = S_W_CUR;
        end
      end
      S_COMMIT: state_nxt_s = S_IDLE;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // Query issue and position commit; the held query address becomes the new position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xpos_r     <= START_X;
      ypos_r     <= START_Y;
      dir_r      <= 4'b0001;
      qdir_r     <= 4'b0000;
      moving_r   <= 1'b0;
      wall_req_r <= 1'b0;
      wall_x_r   <= 10'd0;
      wall_y_r   <= 10'd0;
    end else begin
      case (state_r)
        S_Q_PEND: begin
          if (cand_pend_s[20]) begin
            wall_req_r <= 1'b1;
            wall_x_r   <= cand_pend_s[19:10];
            wall_y_r   <= cand_pend_s[9:0];
            qdir_r     <= pend_r;
          end
        end
        S_Q_CUR: begin
          if (cand_cur_s[20]) begin
            wall_req_r <= 1'b1;
            wall_x_r   <= cand_cur_s[19:10];
            wall_y_r   <= cand_cur_s[9:0];
            qdir_r     <= dir_r;
          end else begin
            moving_r <= 1'b0;
          end
        end
        S_W_PEND: begin
          if (wall_ack) wall_req_r <= 1'b0;
        end
        S_W_CUR: begin
          if (wall_ack) begin
            wall_req_r <= 1'b0;
            if (wall_hit) moving_r <= 1'b0;
          end
        end
        S_COMMIT: begin
          xpos_r   <= wall_x_r;
          ypos_r   <= wall_y_r;
          dir_r    <= qdir_r;
          moving_r <= 1'b1;
        end
        default: wall_req_r <= 1'b0;
      endcase
    end
  end

  assign wall_req     = wall_req_r;
  assign wall_x       = wall_x_r;
  assign wall_y       = wall_y_r;
  assign pm_xpos      = xpos_r;
  assign pm_ypos      = ypos_r;
  assign pm_direction = dir_r;
  assign moving       = moving_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Scenario bench for pacman_move_ctrl: a wall-unit responder model plus a
// query scoreboard that holds the expected address of every wall query.
module tb_pacman_move_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       wall_req;
  logic [9:0] wall_x;
  logic [9:0] wall_y;
  logic       wall_ack = 1'b0;
  logic       wall_hit = 1'b0;
  logic [9:0] pm_xpos;
  logic [9:0] pm_ypos;
  logic [3:0] pm_direction;
  logic       moving;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int query_count = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  bit req_seen = 1'b0;
  logic [9:0] exp_qx[$];
  logic [9:0] exp_qy[$];
  bit hit_q[$];

  pacman_move_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick), .btn(btn),
    .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y), .wall_ack(wall_ack),
    .wall_hit(wall_hit), .pm_xpos(pm_xpos), .pm_ypos(pm_ypos),
    .pm_direction(pm_direction), .moving(moving), .busy(busy)
  );

  always #5 clk = ~clk;

  // Wall unit model: acks after ack_delay waiting cycles, hit taken from hit_q (default free).
  always @(negedge clk) begin
    if (wall_ack) begin
      wall_ack = 1'b0;
      wait_cnt = 0;
    end else if (wall_req) begin
      if (wait_cnt >= ack_delay) begin
        wall_ack = 1'b1;
        wall_hit = (hit_q.size() != 0) ? hit_q.pop_front() : 1'b0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Scoreboard: each new query must match the next expected address.
  always @(negedge clk) begin
    if (wall_req && !req_seen) begin
      logic [9:0] ex;
      logic [9:0] ey;
      req_seen = 1'b1;
      query_count++;
      checks++;
      if (exp_qx.size() == 0) begin
        failures++;
        $display("FAIL query_unexpected got (%0d,%0d) expected no query", wall_x, wall_y);
      end else begin
        ex = exp_qx.pop_front();
        ey = exp_qy.pop_front();
        if (wall_x !== ex || wall_y !== ey) begin
          failures++;
          $display("FAIL query_addr got (%0d,%0d) expected (%0d,%0d)", wall_x, wall_y, ex, ey);
        end
      end
    end else if (!wall_req) begin
      req_seen = 1'b0;
    end
  end

  task automatic push_query(input logic [9:0] x, input logic [9:0] y);
    exp_qx.push_back(x);
    exp_qy.push_back(y);
  endtask

  task automatic frame();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge clk);
    btn = b;
    @(negedge clk);
    btn = 4'b0000;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout got busy=%0b expected busy=0 within 200 cycles", busy);
    end
  endtask

  task automatic step2();
    frame();
    frame();
    wait_idle();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    btn = 4'b0000;
    frame_tick = 1'b0;
    ack_delay = 0;
    hit_q.delete();
    exp_qx.delete();
    exp_qy.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 8;
    if (pm_xpos !== 10'd305) begin failures++; $display("FAIL rst_x got %0d expected 305", pm_xpos); end
    if (pm_ypos !== 10'd350) begin failures++; $display("FAIL rst_y got %0d expected 350", pm_ypos); end
    if (pm_direction !== 4'b0001) begin failures++; $display("FAIL rst_dir got %b expected 0001", pm_direction); end
    if (moving !== 1'b0) begin failures++; $display("FAIL rst_moving got %b expected 0", moving); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b expected 0", busy); end
    if (wall_req !== 1'b0) begin failures++; $display("FAIL rst_req got %b expected 0", wall_req); end
    if (wall_x !== 10'd0 || wall_y !== 10'd0) begin failures++; $display("FAIL rst_addr got (%0d,%0d) expected (0,0)", wall_x, wall_y); end
    if (dut.pend_r !== 4'b0000) begin failures++; $display("FAIL rst_pend got %b expected 0000", dut.pend_r); end
  endtask

  task automatic test_straight();
    apply_reset();
    enable = 1'b1;
    push_query(10'd307, 10'd350);
    step2();
    checks += 2;
    if (pm_xpos !== 10'd307) begin failures++; $display("FAIL straight_x1 got %0d expected 307", pm_xpos); end
    if (moving !== 1'b1) begin failures++; $display("FAIL straight_moving1 got %b expected 1", moving); end
    push_query(10'd309, 10'd350);
    step2();
    checks += 3;
    if (pm_xpos !== 10'd309 || pm_ypos !== 10'd350) begin failures++; $display("FAIL straight_pos2 got (%0d,%0d) expected (309,350)", pm_xpos, pm_ypos); end
    if (pm_direction !== 4'b0001) begin failures++; $display("FAIL straight_dir got %b expected 0001", pm_direction); end
    if (moving !== 1'b1) begin failures++; $display("FAIL straight_moving2 got %b expected 1", moving); end
  endtask

  task automatic test_enable_freeze();
    int qc;
    apply_reset();
    qc = query_count;
    repeat (3) frame();
    wait_idle();
    enable = 1'b1;
    frame();
    wait_idle();
    checks += 2;
    if (pm_xpos !== 10'd305) begin failures++; $display("FAIL freeze_x got %0d expected 305", pm_xpos); end
    if (query_count !== qc) begin failures++; $display("FAIL freeze_queries got %0d expected %0d", query_count, qc); end
    push_query(10'd307, 10'd350);
    frame();
    wait_idle();
    checks++;
    if (pm_xpos !== 10'd307) begin failures++; $display("FAIL freeze_resume_x got %0d expected 307", pm_xpos); end
  endtask

  task automatic test_turn_up();
    apply_reset();
    enable = 1'b1;
    press(4'b0100);
    push_query(10'd305, 10'd348);
    step2();
    checks += 3;
    if (pm_xpos !== 10'd305 || pm_ypos !== 10'd348) begin failures++; $display("FAIL up_pos got (%0d,%0d) expected (305,348)", pm_xpos, pm_ypos); end
    if (pm_direction !== 4'b0100) begin failures++; $display("FAIL up_dir got %b expected 0100", pm_direction); end
    if (dut.pend_r !== 4'b0000) begin failures++; $display("FAIL up_pend got %b expected 0000", dut.pend_r); end
  endtask

  task automatic test_blocked_turn();
    apply_reset();
    enable = 1'b1;
    press(4'b1000);
    hit_q.push_back(1'b1);
    hit_q.push_back(1'b0);
    push_query(10'd305, 10'd352);
    push_query(10'd307, 10'd350);
    step2();
    checks += 3;
    if (pm_xpos !== 10'd307 || pm_ypos !== 10'd350) begin failures++; $display("FAIL blk_pos got (%0d,%0d) expected (307,350)", pm_xpos, pm_ypos); end
    if (pm_direction !== 4'b0001) begin failures++; $display("FAIL blk_dir got %b expected 0001", pm_direction); end
    if (dut.pend_r !== 4'b1000) begin failures++; $display("FAIL blk_pend got %b expected 1000", dut.pend_r); end
    push_query(10'd307, 10'd352);
    step2();
    checks += 2;
    if (pm_ypos !== 10'd352 || pm_direction !== 4'b1000) begin failures++; $display("FAIL blk_later got y=%0d dir=%b expected y=352 dir=1000", pm_ypos, pm_direction); end
    if (dut.pend_r !== 4'b0000) begin failures++; $display("FAIL blk_later_pend got %b expected 0000", dut.pend_r); end
  endtask

  task automatic test_x_max();
    int qc;
    apply_reset();
    enable = 1'b1;
    for (int i = 1; i <= 224; i++) begin
      push_query(10'(305 + 2 * i), 10'd350);
      step2();
    end
    checks++;
    if (pm_xpos !== 10'd753) begin failures++; $display("FAIL xmax_reach got %0d expected 753", pm_xpos); end
    qc = query_count;
    step2();
    checks += 3;
    if (query_count !== qc) begin failures++; $display("FAIL xmax_query got %0d queries expected %0d", query_count, qc); end
    if (moving !== 1'b0) begin failures++; $display("FAIL xmax_moving got %b expected 0", moving); end
    if (pm_xpos !== 10'd753 || pm_direction !== 4'b0001) begin failures++; $display("FAIL xmax_hold got x=%0d dir=%b expected x=753 dir=0001", pm_xpos, pm_direction); end
  endtask

  task automatic test_slow_ack();
    int qc;
    apply_reset();
    enable = 1'b1;
    ack_delay = 20;
    qc = query_count;
    push_query(10'd307, 10'd350);
    frame();
    frame();
    frame();
    checks++;
    if (wall_req !== 1'b1 || wall_x !== 10'd307 || wall_y !== 10'd350) begin failures++; $display("FAIL slow_hold1 got req=%b (%0d,%0d) expected req=1 (307,350)", wall_req, wall_x, wall_y); end
    frame();
    frame();
    checks += 2;
    if (wall_req !== 1'b1 || wall_x !== 10'd307 || wall_y !== 10'd350) begin failures++; $display("FAIL slow_hold2 got req=%b (%0d,%0d) expected req=1 (307,350)", wall_req, wall_x, wall_y); end
    if (pm_xpos !== 10'd305) begin failures++; $display("FAIL slow_early got %0d expected 305", pm_xpos); end
    wait_idle();
    checks += 2;
    if (pm_xpos !== 10'd307) begin failures++; $display("FAIL slow_x got %0d expected 307", pm_xpos); end
    if (query_count !== qc + 1) begin failures++; $display("FAIL slow_one_step got %0d queries expected %0d", query_count - qc, 1); end
    ack_delay = 0;
    push_query(10'd309, 10'd350);
    frame();
    wait_idle();
    checks++;
    if (pm_xpos !== 10'd309) begin failures++; $display("FAIL slow_div_phase got %0d expected 309", pm_xpos); end
  endtask

  task automatic test_reset_mid_query();
    bit seen = 1'b0;
    apply_reset();
    enable = 1'b1;
    ack_delay = 30;
    press(4'b0100);
    push_query(10'd305, 10'd348);
    frame();
    frame();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wall_req) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL mid_wait got wall_req=0 expected wall_req=1 within 20 cycles"); end
    #2;
    rst = 1'b1;
    #1;
    checks += 4;
    if (wall_req !== 1'b0) begin failures++; $display("FAIL mid_req got %b expected 0", wall_req); end
    if (pm_xpos !== 10'd305 || pm_ypos !== 10'd350 || pm_direction !== 4'b0001) begin failures++; $display("FAIL mid_outputs got (%0d,%0d,%b) expected (305,350,0001)", pm_xpos, pm_ypos, pm_direction); end
    if (dut.pend_r !== 4'b0000) begin failures++; $display("FAIL mid_pend got %b expected 0000", dut.pend_r); end
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got %b expected 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
  endtask

  initial begin
    test_reset();
    test_straight();
    test_enable_freeze();
    test_turn_up();
    test_blocked_turn();
    test_x_max();
    test_slow_ack();
    test_reset_mid_query();
    checks++;
    if (exp_qx.size() != 0) begin failures++; $display("FAIL query_leftover got %0d expected 0", exp_qx.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
